// File: rtl/seq_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock; result N cycles after start.
// start is taken only when idle; requests while busy are dropped, not queued.
module seq_bcd_converter #(
  parameter int N = 14,
  parameter int D = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   bin_in,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd_out,
  output logic           neg,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [4*D-1:0] NINES = {D{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   shreg;
  logic [4*D-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           sign_q;
  logic           ovf_q;

  logic [4*D-1:0] adj;
  logic [4*D-1:0] acc_nxt;
  logic           shout;
  logic           ovf_nxt;
  logic [N-1:0]   mag;

  // Add-3 correction on every digit, then the single-bit shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < D; i++) begin
      adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    acc_nxt = {adj[4*D-2:0], shreg[N-1]};
    shout   = adj[4*D-1];
    ovf_nxt = ovf_q | shout;
  end

  // Negating the most negative value wraps to 2^(N-1), which is the correct unsigned magnitude.
  always_comb begin
    mag = (signed_mode && bin_in[N-1]) ? -bin_in : bin_in;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg  <= mag;
            acc    <= '0;
            cnt    <= '0;
            sign_q <= signed_mode & bin_in[N-1];
            ovf_q  <= 1'b0;
          end
        end
        SHIFT: begin
          acc   <= acc_nxt;
          shreg <= shreg << 1;
          ovf_q <= ovf_nxt;
          cnt   <= cnt + CW'(1);
          // Publish on the final step; outputs stay frozen during a conversion.
          if (cnt == LAST) begin
            bcd_out  <= ovf_nxt ? NINES : acc_nxt;
            neg      <= sign_q;
            overflow <= ovf_nxt;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Bench for seq_bcd_converter: directed vectors with a queue-based scoreboard per instance.
module tb_seq_bcd_converter;

  typedef struct packed {
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic        start0 = 0, sm0 = 0;
  logic [13:0] bin0 = '0;
  logic        busy0, done0, neg0, ovf0;
  logic [15:0] bcd0;

  logic        start1 = 0, sm1 = 0;
  logic [7:0]  bin1 = '0;
  logic        busy1, done1, neg1, ovf1;
  logic [11:0] bcd1;

  logic        start2 = 0, sm2 = 0;
  logic [19:0] bin2 = '0;
  logic        busy2, done2, neg2, ovf2;
  logic [23:0] bcd2;

  seq_bcd_converter #(.N(14), .D(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0), .bin_in(bin0),
    .busy(busy0), .done(done0), .bcd_out(bcd0), .neg(neg0), .overflow(ovf0));
  seq_bcd_converter #(.N(8), .D(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .bin_in(bin1),
    .busy(busy1), .done(done1), .bcd_out(bcd1), .neg(neg1), .overflow(ovf1));
  seq_bcd_converter #(.N(20), .D(6)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .neg(neg2), .overflow(ovf2));

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference via repeated division, independent of the shift-add structure.
  function automatic exp_t model(input logic [63:0] v_in, input int n, input int d, input bit s);
    exp_t r;
    logic [63:0] v, mag, limit;
    v = v_in & ((64'd1 << n) - 64'd1);
    r = '0;
    r.neg = s && v[n-1];
    mag = r.neg ? ((64'd1 << n) - v) : v;
    limit = 64'd1;
    for (int i = 0; i < d; i++) limit = limit * 64'd10;
    if (mag >= limit) begin
      r.ovf = 1'b1;
      for (int i = 0; i < d; i++) r.bcd[4*i +: 4] = 4'h9;
    end else begin
      for (int i = 0; i < d; i++) begin
        r.bcd[4*i +: 4] = 4'(mag % 64'd10);
        mag = mag / 64'd10;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        checks++; fails++;
        $display("FAIL dut0_unexpected_done: got done=1, expected no result pending");
      end else begin
        e0 = q0.pop_front();
        chk("dut0_bcd", 64'(bcd0), 64'(e0.bcd[15:0]));
        chk("dut0_neg", 64'(neg0), 64'(e0.neg));
        chk("dut0_ovf", 64'(ovf0), 64'(e0.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; fails++;
        $display("FAIL dut1_unexpected_done: got done=1, expected no result pending");
      end else begin
        e1 = q1.pop_front();
        chk("dut1_bcd", 64'(bcd1), 64'(e1.bcd[11:0]));
        chk("dut1_neg", 64'(neg1), 64'(e1.neg));
        chk("dut1_ovf", 64'(ovf1), 64'(e1.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        checks++; fails++;
        $display("FAIL dut2_unexpected_done: got done=1, expected no result pending");
      end else begin
        e2 = q2.pop_front();
        chk("dut2_bcd", 64'(bcd2), 64'(e2.bcd));
        chk("dut2_neg", 64'(neg2), 64'(e2.neg));
        chk("dut2_ovf", 64'(ovf2), 64'(e2.ovf));
      end
    end
  end

  // Issue one conversion on dut0 and return in the cycle done is high.
  task automatic run0(input logic [13:0] v, input bit s, input bit poke, input bit hold);
    int lat;
    bit drop;
    q0.push_back(model(64'(v), 14, 4, s));
    start0 = 1'b1; bin0 = v; sm0 = s;
    @(posedge clk); #1;
    chk("busy_after_start", 64'(busy0), 64'd1);
    if (!hold) start0 = 1'b0;
    lat = 0; drop = 0;
    while (!done0 && lat < 40) begin
      if (poke && lat == 5) begin start0 = 1'b1; bin0 = 14'd42; sm0 = 1'b1; end
      else if (poke && lat == 6) start0 = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (!done0 && !busy0) drop = 1;
    end
    chk("latency", 64'(lat), 64'd14);
    chk("busy_held", 64'(drop), 64'd0);
    chk("busy_at_done", 64'(busy0), 64'd0);
  endtask

  task automatic conv0(input logic [13:0] v, input bit s, input bit poke);
    run0(v, s, poke, 1'b0);
    @(posedge clk); #1;
    chk("done_fall", 64'(done0), 64'd0);
  endtask

  task automatic go1(input logic [7:0] v, input bit s);
    q1.push_back(model(64'(v), 8, 3, s));
    start1 = 1'b1; bin1 = v; sm1 = s;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 40 && !done1; i++) begin @(posedge clk); #1; end
    chk("dut1_done_seen", 64'(done1), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic go2(input logic [19:0] v, input bit s);
    q2.push_back(model(64'(v), 20, 6, s));
    start2 = 1'b1; bin2 = v; sm2 = s;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 60 && !done2; i++) begin @(posedge clk); #1; end
    chk("dut2_done_seen", 64'(done2), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_bcd", 64'(bcd0), 64'd0);
    chk("rst_neg", 64'(neg0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    conv0(14'd9999, 1'b0, 1'b0);
    chk("hold_9999", 64'(bcd0), 64'h9999);
    conv0(14'd0, 1'b0, 1'b0);
    conv0(14'd12345, 1'b0, 1'b0);
    conv0(14'h3FFF, 1'b1, 1'b0);
    conv0(14'h2000, 1'b1, 1'b0);
    conv0(14'd0, 1'b1, 1'b0);
    conv0(14'd777, 1'b0, 1'b1);

    // start held through done: the second request is taken on the edge after done.
    run0(14'd100, 1'b0, 1'b0, 1'b1);
    q0.push_back(model(64'd255, 14, 4, 1'b0));
    bin0 = 14'd255; sm0 = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("b2b_done_fall", 64'(done0), 64'd0);
    chk("b2b_busy", 64'(busy0), 64'd1);
    gap = 1;
    while (!done0 && gap < 40) begin @(posedge clk); #1; gap++; end
    chk("b2b_gap", 64'(gap), 64'd15);
    chk("b2b_bcd", 64'(bcd0), 64'h0255);
    @(posedge clk); #1;

    conv0(14'h2000, 1'b1, 1'b0);
    start0 = 1'b1; bin0 = 14'd1234; sm0 = 1'b0;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    chk("abort_bcd", 64'(bcd0), 64'd0);
    chk("abort_ovf", 64'(ovf0), 64'd0);
    chk("abort_neg", 64'(neg0), 64'd0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done0) seen = 1; end
    chk("abort_no_done", 64'(seen), 64'd0);
    conv0(14'd4321, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) conv0(14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)), 1'b0);

    go1(8'd255, 1'b0);
    go1(8'd0, 1'b1);
    go1(8'h80, 1'b1);
    go1(8'hFF, 1'b1);
    go1(8'd100, 1'b0);
    for (int i = 0; i < 4; i++) go1(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    go2(20'd999999, 1'b0);
    go2(20'd1000000, 1'b0);
    go2(20'h80000, 1'b1);
    go2(20'hFFFFF, 1'b0);
    go2(20'hFFFFF, 1'b1);
    for (int i = 0; i < 4; i++) go2(20'($urandom_range(0, 1048575)), 1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
